// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: fill byte, counter width,
// state encoding and the SPI_MODE3_EN mode selector values.
package spi_pkg;

    localparam logic [7:0] FILL_DEFAULT = 8'hFF;
    localparam int         BITCNT_W     = 3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic MODE_0 = 1'b0;
    localparam logic MODE_3 = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one SPI pin with single-cycle
// rise/fall pulses taken against one extra delayed flop.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;
    logic              w_lvl;

    assign w_lvl = r_sync[STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= {STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_dly  <= w_lvl;
        end
    end

    assign o_rise = w_lvl & ~r_dly;
    assign o_fall = ~w_lvl & r_dly;

endmodule

// File: rtl/spi_responder.sv
// SPI device-side responder, mode 0, MSB first, 8-bit frames.
// Define SPI_MODE3_EN to add the MODE3 input (CPOL=1/CPHA=1).
module spi_responder
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL        = FILL_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       nSS,
`ifdef SPI_MODE3_EN
    input  logic       MODE3,
`endif
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] TXDATA,
    input  logic       TXVALID,
    output logic       TXTAKEN,
    output logic [7:0] RXDATA,
    output logic       RXVALID,
    output logic       SELECTED
);

    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_nss_rise;
    logic                   w_nss_fall;
    logic                   w_mosi;
    logic                   w_active;
    logic                   w_skip;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [0:0]             r_state;
    logic [BITCNT_W-1:0]    r_bitcnt;
    logic [7:0]             r_rx;
    logic [7:0]             r_tx;
    logic [7:0]             r_rxdata;
    logic                   r_rxvalid;
    logic                   r_txtaken;

    spi_sync #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b0)
    ) u_sck (
        .CLK   (CLK),
        .RST   (RST),
        .i_d   (SCK),
        .o_rise(w_sck_rise),
        .o_fall(w_sck_fall)
    );

    // Reset low so a select still held across RST yields no fall edge
    spi_sync #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b0)
    ) u_nss (
        .CLK   (CLK),
        .RST   (RST),
        .i_d   (nSS),
        .o_rise(w_nss_rise),
        .o_fall(w_nss_fall)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_active = (r_state == ST_ACTIVE);

`ifdef SPI_MODE3_EN
    logic r_first;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_first <= 1'b0;
        end else if (!w_active) begin
            r_first <= w_nss_fall;
        end else if (w_sck_fall) begin
            r_first <= 1'b0;
        end
    end

    // CPOL=1 opens with a fall; the first byte is already loaded then
    assign w_skip = (MODE3 == MODE_3) & r_first;
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_rx      <= '0;
            r_tx      <= FILL;
            r_rxdata  <= '0;
            r_rxvalid <= 1'b0;
            r_txtaken <= 1'b0;
        end else begin
            r_rxvalid <= 1'b0;
            r_txtaken <= 1'b0;
            if (!w_active) begin
                if (w_nss_fall) begin
                    r_state   <= ST_ACTIVE;
                    r_bitcnt  <= '0;
                    r_tx      <= TXVALID ? TXDATA : FILL;
                    r_txtaken <= TXVALID;
                end
            end else if (w_nss_rise) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= '0;
                r_rx     <= '0;
                r_tx     <= FILL;
            end else if (w_sck_rise) begin
                r_rx     <= {r_rx[6:0], w_mosi};
                r_bitcnt <= r_bitcnt + 1'b1;
                if (r_bitcnt == '1) begin
                    r_rxdata  <= {r_rx[6:0], w_mosi};
                    r_rxvalid <= 1'b1;
                end
            end else if (w_sck_fall && !w_skip) begin
                if (r_bitcnt == '0) begin
                    r_tx      <= TXVALID ? TXDATA : FILL;
                    r_txtaken <= TXVALID;
                end else begin
                    r_tx <= {r_tx[6:0], 1'b1};
                end
            end
        end
    end

    assign MISO     = w_active ? r_tx[7] : 1'b1;
    assign MISO_OE  = w_active;
    assign SELECTED = w_active;
    assign TXTAKEN  = r_txtaken;
    assign RXDATA   = r_rxdata;
    assign RXVALID  = r_rxvalid;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: bus-functional SPI master, TX producer
// queue and an RX scoreboard checked on every RXVALID pulse.
module tb_spi_responder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SCK;
    logic       MOSI;
    logic       nSS;
    logic       MISO;
    logic       MISO_OE;
    logic [7:0] TXDATA;
    logic       TXVALID;
    logic       TXTAKEN;
    logic [7:0] RXDATA;
    logic       RXVALID;
    logic       SELECTED;

    int compared = 0;
    int mismatched = 0;
    int taken_cnt = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];

    always #5 CLK = ~CLK;

    spi_responder dut (
        .CLK     (CLK),
        .RST     (RST),
        .SCK     (SCK),
        .MOSI    (MOSI),
        .nSS     (nSS),
`ifdef SPI_MODE3_EN
        .MODE3   (1'b0),
`endif
        .MISO    (MISO),
        .MISO_OE (MISO_OE),
        .TXDATA  (TXDATA),
        .TXVALID (TXVALID),
        .TXTAKEN (TXTAKEN),
        .RXDATA  (RXDATA),
        .RXVALID (RXVALID),
        .SELECTED(SELECTED)
    );

    // Producer: offers txq head, drops it once the DUT takes it
    always @(negedge CLK) begin
        if (TXTAKEN) begin
            taken_cnt++;
            if (txq.size() != 0) void'(txq.pop_front());
        end
        TXVALID = (txq.size() != 0);
        TXDATA  = (txq.size() != 0) ? txq[0] : 8'h00;
    end

    always @(negedge CLK) begin
        if (RXVALID) begin
            compared++;
            if (rxq.size() == 0) begin
                mismatched++;
                $display("FAIL rxvalid_unexpected: got %02h want no pulse", RXDATA);
            end else begin
                logic [7:0] e;
                e = rxq.pop_front();
                if (RXDATA !== e) begin
                    mismatched++;
                    $display("FAIL rxdata: got %02h want %02h", RXDATA, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic sel();
        nSS = 1'b0;
        clks(8);
    endtask

    task automatic desel();
        clks(4);
        nSS = 1'b1;
        clks(10);
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits,
                        output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[7-i];
            clks(4);
            SCK = 1'b1;
            mi = {mi[6:0], MISO};
            clks(4);
            SCK = 1'b0;
        end
    endtask

    typedef struct {
        logic       txv;
        logic [7:0] txd;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        int         exp_taken;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [7:0] got0;
        logic [7:0] got1;
        int         t0;

        tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
        tbl[1] = '{1'b0, 8'h00, 8'h55, 8'hFF, 0};
        tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};
        tbl[3] = '{1'b1, 8'h81, 8'h81, 8'h81, 1};
        tbl[4] = '{1'b1, 8'h7E, 8'h00, 8'h7E, 1};

        RST = 1'b1; SCK = 1'b0; MOSI = 1'b0; nSS = 1'b1;
        clks(3);
        chk("rst_miso", MISO, 1);
        chk("rst_oe", MISO_OE, 0);
        chk("rst_rxdata", RXDATA, 8'h00);
        chk("rst_rxvalid", RXVALID, 0);
        chk("rst_sel", SELECTED, 0);
        chk("rst_taken", TXTAKEN, 0);
        RST = 1'b0;
        clks(5);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].txv) txq.push_back(tbl[i].txd);
            clks(2);
            t0 = taken_cnt;
            rxq.push_back(tbl[i].mosi);
            sel();
            chk("sel_active", SELECTED, 1);
            xfer(tbl[i].mosi, 8, got0);
            desel();
            chk("tbl_miso", got0, tbl[i].exp_miso);
            chk("tbl_taken", taken_cnt - t0, tbl[i].exp_taken);
            chk("tbl_rxdata", RXDATA, tbl[i].mosi);
            chk("tbl_oe_idle", MISO_OE, 0);
        end

        // Back-to-back bytes in one select
        txq.push_back(8'h11);
        txq.push_back(8'h22);
        clks(2);
        t0 = taken_cnt;
        rxq.push_back(8'hC3);
        rxq.push_back(8'h5A);
        sel();
        xfer(8'hC3, 8, got0);
        xfer(8'h5A, 8, got1);
        desel();
        chk("b2b_miso0", got0, 8'h11);
        chk("b2b_miso1", got1, 8'h22);
        chk("b2b_taken", taken_cnt - t0, 2);
        chk("b2b_rxdata", RXDATA, 8'h5A);

        // Abort after 5 bits, then a clean frame
        sel();
        xfer(8'hF0, 5, got0);
        desel();
        chk("abort_rxdata", RXDATA, 8'h5A);
        chk("abort_oe", MISO_OE, 0);
        chk("abort_miso", MISO, 1);
        rxq.push_back(8'h81);
        sel();
        xfer(8'h81, 8, got0);
        desel();
        chk("post_abort_rx", RXDATA, 8'h81);
        chk("post_abort_miso", got0, 8'hFF);

        // nSS rise coincident with the 8th SCK rise
        sel();
        xfer(8'hE7, 7, got0);
        MOSI = 1'b1;
        clks(4);
        SCK = 1'b1;
        nSS = 1'b1;
        clks(4);
        SCK = 1'b0;
        clks(10);
        chk("race_rxdata", RXDATA, 8'h81);
        chk("race_oe", MISO_OE, 0);

        // Reset mid-byte, then a fresh frame from bit 0
        sel();
        xfer(8'hAA, 4, got0);
        RST = 1'b1;
        #1;
        chk("midrst_miso", MISO, 1);
        chk("midrst_oe", MISO_OE, 0);
        chk("midrst_rxvalid", RXVALID, 0);
        chk("midrst_rxdata", RXDATA, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        xfer(8'hAA, 4, got0);
        chk("midrst_nosel", SELECTED, 0);
        desel();
        txq.push_back(8'h5B);
        clks(2);
        t0 = taken_cnt;
        rxq.push_back(8'h96);
        sel();
        xfer(8'h96, 8, got0);
        desel();
        chk("resume_miso", got0, 8'h5B);
        chk("resume_rx", RXDATA, 8'h96);
        chk("resume_taken", taken_cnt - t0, 1);

        clks(20);
        chk("rxq_drained", rxq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
